mu_pipe: RTL

//  Parametrised, pipelined RV32M/RV64M multiply unit. Successor to the fixed-width multiply unit.

---
 rtl/mu_pipe.sv | 101 ++++++++++
 1 files changed

// File: rtl/mu_pipe.sv
// Pipelined RV32M/RV64M multiply unit: in-order results after STAGES cycles, with tag.
// Optional synchronous pipe flush is compiled in when MU_FLUSH_EN is defined.
module mu_pipe #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned STAGES = 3,
   parameter int unsigned TAGW   = 5
) (
   input  logic            clk,
   input  logic            rst_n,
`ifdef MU_FLUSH_EN
   input  logic            flush,
`endif
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [1:0]      mulctl,
   input  logic [TAGW-1:0] in_tag,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] mulres,
   output logic [TAGW-1:0] out_tag
);

   logic                   flush_w;
   logic                   stall;
   logic                   a_sgn;
   logic                   b_sgn;
   logic signed [2*XLEN-1:0] a_ext;
   logic signed [2*XLEN-1:0] b_ext;
   logic signed [2*XLEN-1:0] prod;
   logic [XLEN-1:0]        sel;

   logic                   valid_q [STAGES];
   logic [XLEN-1:0]        res_q   [STAGES];
   logic [TAGW-1:0]        tag_q   [STAGES];

`ifdef MU_FLUSH_EN
   assign flush_w = flush;
`else
   assign flush_w = 1'b0;
`endif

   assign out_valid = valid_q[STAGES-1];
   assign mulres    = res_q[STAGES-1];
   assign out_tag   = tag_q[STAGES-1];
   assign stall     = out_valid & ~out_ready;
   assign in_ready  = ~stall;

   // Extending straight to 2*XLEN keeps the low 2*XLEN product bits exact,
   // which is all either result select needs.
   always_comb begin
      a_sgn = (mulctl == 2'b01) || (mulctl == 2'b10);
      b_sgn = (mulctl == 2'b01);
      a_ext = {{XLEN{a_sgn & a[XLEN-1]}}, a};
      b_ext = {{XLEN{b_sgn & b[XLEN-1]}}, b};
      prod  = a_ext * b_ext;
      if (mulctl == 2'b00) begin
         sel = prod[XLEN-1:0];
      end else begin
         sel = prod[2*XLEN-1:XLEN];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(STAGES); i++) begin
            valid_q[i] <= 1'b0;
         end
      end else if (flush_w) begin
         for (int i = 0; i < int'(STAGES); i++) begin
            valid_q[i] <= 1'b0;
         end
      end else if (!stall) begin
         valid_q[0] <= in_valid;
         for (int i = 1; i < int'(STAGES); i++) begin
            valid_q[i] <= valid_q[i-1];
         end
      end
   end

   // Stage 1 only loads on a real op so undriven operands during bubbles never reach the outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(STAGES); i++) begin
            res_q[i] <= '0;
            tag_q[i] <= '0;
         end
      end else if (!stall && !flush_w) begin
         if (in_valid) begin
            res_q[0] <= sel;
            tag_q[0] <= in_tag;
         end
         for (int i = 1; i < int'(STAGES); i++) begin
            res_q[i] <= res_q[i-1];
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

endmodule
